// File: rtl/spi_xfer_ctrl_pkg.sv
// Shared definitions for the SPI transfer sequencer: CPU move-interface widths and opcodes,
// register map, STATUS bit positions and FSM state encoding.
`ifndef SPI_XFER_CTRL_DEFS
`define SPI_XFER_CTRL_DEFS
`define W_REG 5
`define W_CPU 32
`define W_SPI_CTRL 2
`define MT 2'd1
`define MF 2'd2
`endif

package spi_xfer_ctrl_pkg;

  localparam logic [`W_REG-1:0] SPI_CTRL   = `W_REG'(0);
  localparam logic [`W_REG-1:0] SPI_STATUS = `W_REG'(1);
  localparam logic [`W_REG-1:0] SPI_TXDATA = `W_REG'(2);
  localparam logic [`W_REG-1:0] SPI_RXDATA = `W_REG'(3);

  localparam int ST_BUSY  = 0;
  localparam int ST_TXF   = 1;
  localparam int ST_RXF   = 2;
  localparam int ST_DONE  = 3;
  localparam int ST_RXOVF = 4;
  localparam int ST_TXOVF = 5;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOAD,
    SHIFT,
    HOLD
  } state_t;

endpackage

// File: rtl/spi_xfer_ctrl.sv
// CP0-mapped SPI burst sequencer: one-entry TX/RX holding registers, chip-select framing,
// byte-at-a-time start/done handshake with the shift engines.
module spi_xfer_ctrl
  import spi_xfer_ctrl_pkg::*;
#(
  parameter int W_DATA   = 8,
  parameter int W_LEN    = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`W_REG-1:0]      addr,
  input  logic [`W_CPU-1:0]      wd,
  input  logic [`W_SPI_CTRL-1:0] ctrl,
  output logic [`W_CPU-1:0]      data_out,
  output logic                   eng_start,
  output logic [W_DATA-1:0]      eng_tx_data,
  input  logic                   eng_done,
  input  logic [W_DATA-1:0]      eng_rx_data,
  output logic                   spi_cs_n,
  output logic                   irq
);

  localparam int CYC_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int W_CYC   = $clog2(CYC_MAX + 1);

  state_t             state_q;
  logic [W_CYC-1:0]   cyc_q;
  logic [W_LEN-1:0]   cnt_q, len_q;
  logic               go_q, abort_q, irq_en_q, cs_n_q, eng_start_q;
  logic [W_DATA-1:0]  eng_tx_data_q;
  logic [W_DATA-1:0]  tx_q, tx_d, rx_q, rx_d;
  logic               tx_full_q, tx_full_d, rx_full_q, rx_full_d;
  logic               done_q, done_d, rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;

  logic wr, rd, wr_ctrl, wr_stat, wr_tx, rd_rx, pop, cap, fin;
  logic unused_wd;

  assign wr      = (ctrl == `MT);
  assign rd      = (ctrl == `MF);
  assign wr_ctrl = wr && (addr == SPI_CTRL);
  assign wr_stat = wr && (addr == SPI_STATUS);
  assign wr_tx   = wr && (addr == SPI_TXDATA);
  assign rd_rx   = rd && (addr == SPI_RXDATA);
  assign pop     = (state_q == LOAD) && tx_full_q && !abort_q;
  assign cap     = (state_q == SHIFT) && eng_done;
  assign fin     = (state_q == HOLD) && (cyc_q == W_CYC'(CS_HOLD - 1));
  assign unused_wd = ^wd[`W_CPU-1:8+W_LEN];

  // A pop and a CPU access in the same cycle both resolve in favour of the CPU's view.
  always_comb begin
    tx_d      = tx_q;
    tx_full_d = tx_full_q;
    tx_ovf_d  = tx_ovf_q;
    rx_d      = rx_q;
    rx_full_d = rx_full_q;
    rx_ovf_d  = rx_ovf_q;
    done_d    = done_q;
    if (pop) tx_full_d = 1'b0;
    if (wr_tx) begin
      if (tx_full_q && !pop) begin
        tx_ovf_d = 1'b1;
      end else begin
        tx_d      = wd[W_DATA-1:0];
        tx_full_d = 1'b1;
      end
    end
    if (rd_rx) rx_full_d = 1'b0;
    if (cap) begin
      if (rx_full_q && !rd_rx) begin
        rx_ovf_d = 1'b1;
      end else begin
        rx_d      = eng_rx_data;
        rx_full_d = 1'b1;
      end
    end
    if (wr_stat) begin
      if (wd[ST_DONE])  done_d   = 1'b0;
      if (wd[ST_RXOVF]) rx_ovf_d = 1'b0;
      if (wd[ST_TXOVF]) tx_ovf_d = 1'b0;
    end
    if (fin) done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      cnt_q         <= '0;
      len_q         <= '0;
      go_q          <= 1'b0;
      abort_q       <= 1'b0;
      irq_en_q      <= 1'b0;
      cs_n_q        <= 1'b1;
      eng_start_q   <= 1'b0;
      eng_tx_data_q <= '0;
      tx_q          <= '0;
      tx_full_q     <= 1'b0;
      tx_ovf_q      <= 1'b0;
      rx_q          <= '0;
      rx_full_q     <= 1'b0;
      rx_ovf_q      <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      tx_q        <= tx_d;
      tx_full_q   <= tx_full_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_q        <= rx_d;
      rx_full_q   <= rx_full_d;
      rx_ovf_q    <= rx_ovf_d;
      done_q      <= done_d;
      eng_start_q <= 1'b0;
      go_q        <= wr_ctrl && wd[0] && (state_q == IDLE);
      if (wr_ctrl) begin
        irq_en_q <= wd[2];
        len_q    <= wd[8 +: W_LEN];
      end
      if (wr_ctrl && wd[1] && (state_q != IDLE)) abort_q <= 1'b1;
      case (state_q)
        IDLE: begin
          abort_q <= 1'b0;
          if (go_q) begin
            state_q <= SETUP;
            cnt_q   <= len_q;
            cyc_q   <= '0;
            cs_n_q  <= 1'b0;
          end
        end
        SETUP: begin
          if (abort_q) begin
            state_q <= HOLD;
            cyc_q   <= '0;
          end else if (cyc_q == W_CYC'(CS_SETUP - 1)) begin
            state_q <= LOAD;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + W_CYC'(1);
          end
        end
        LOAD: begin
          if (abort_q) begin
            state_q <= HOLD;
            cyc_q   <= '0;
          end else if (tx_full_q) begin
            eng_tx_data_q <= tx_q;
            eng_start_q   <= 1'b1;
            state_q       <= SHIFT;
          end
        end
        SHIFT: begin
          if (eng_done) begin
            if (abort_q || (cnt_q == '0)) begin
              state_q <= HOLD;
              cyc_q   <= '0;
            end else begin
              cnt_q   <= cnt_q - W_LEN'(1);
              state_q <= LOAD;
            end
          end
        end
        HOLD: begin
          abort_q <= 1'b0;
          if (fin) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
          end else begin
            cyc_q <= cyc_q + W_CYC'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    if (rd) begin
      case (addr)
        SPI_CTRL: begin
          data_out[8 +: W_LEN] = len_q;
          data_out[2]          = irq_en_q;
        end
        SPI_STATUS: begin
          data_out[ST_BUSY]  = (state_q != IDLE);
          data_out[ST_TXF]   = tx_full_q;
          data_out[ST_RXF]   = rx_full_q;
          data_out[ST_DONE]  = done_q;
          data_out[ST_RXOVF] = rx_ovf_q;
          data_out[ST_TXOVF] = tx_ovf_q;
        end
        SPI_RXDATA: data_out[W_DATA-1:0] = rx_q;
        default: ;
      endcase
    end
  end

  assign eng_start   = eng_start_q;
  assign eng_tx_data = eng_tx_data_q;
  assign spi_cs_n    = cs_n_q;
  assign irq         = done_q & irq_en_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed-sequence bench for spi_xfer_ctrl with random data bytes and engine delays,
// checked against a register-level model of the holding registers and sticky flags.
module tb_spi_xfer_ctrl;
  import spi_xfer_ctrl_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [`W_REG-1:0]      addr;
  logic [`W_CPU-1:0]      wd;
  logic [`W_SPI_CTRL-1:0] ctrl;
  logic [`W_CPU-1:0]      data_out;
  logic                   eng_start;
  logic [7:0]             eng_tx_data;
  logic                   eng_done;
  logic [7:0]             eng_rx_data;
  logic                   spi_cs_n;
  logic                   irq;

  int nvec = 0;
  int nfail = 0;
  int n_start = 0;

  // Model: what software should observe through the register map.
  bit         m_busy, m_tx_full, m_rx_full, m_done, m_rx_ovf, m_tx_ovf;
  logic [7:0] m_tx, m_rx;

  spi_xfer_ctrl dut (
    .clk(clk), .rst(rst), .addr(addr), .wd(wd), .ctrl(ctrl), .data_out(data_out),
    .eng_start(eng_start), .eng_tx_data(eng_tx_data), .eng_done(eng_done),
    .eng_rx_data(eng_rx_data), .spi_cs_n(spi_cs_n), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (rst && eng_start) n_start++;

  function automatic logic [31:0] m_status();
    return {26'b0, m_tx_ovf, m_rx_ovf, m_done, m_rx_full, m_tx_full, m_busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cpu_wr(input logic [`W_REG-1:0] a, input logic [31:0] d);
    addr = a; wd = d; ctrl = `MT;
    @(posedge clk); #1;
    ctrl = 2'd0;
  endtask

  task automatic cpu_rd(input logic [`W_REG-1:0] a, output logic [31:0] d);
    addr = a; ctrl = `MF;
    #1 d = data_out;
    @(posedge clk); #1;
    ctrl = 2'd0;
  endtask

  task automatic txwr(input logic [7:0] b);
    cpu_wr(SPI_TXDATA, {24'b0, b});
    if (m_tx_full) m_tx_ovf = 1;
    else begin m_tx = b; m_tx_full = 1; end
  endtask

  task automatic go(input logic [7:0] len, input bit irq_en);
    cpu_wr(SPI_CTRL, {16'b0, len, 5'b0, irq_en, 2'b01});
    m_busy = 1;
  endtask

  task automatic st_chk(input string tag);
    logic [31:0] d;
    cpu_rd(SPI_STATUS, d);
    chk(tag, d, m_status());
  endtask

  task automatic rdrx_chk(input string tag);
    logic [31:0] d;
    cpu_rd(SPI_RXDATA, d);
    chk(tag, d, {24'b0, m_rx});
    m_rx_full = 0;
  endtask

  task automatic w1c(input logic [31:0] mask);
    cpu_wr(SPI_STATUS, mask);
    if (mask[3]) m_done = 0;
    if (mask[4]) m_rx_ovf = 0;
    if (mask[5]) m_tx_ovf = 0;
  endtask

  task automatic start_chk(input string tag);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (eng_start === 1'b1) ok = 1;
      else begin @(posedge clk); #1; end
    end
    chk({tag, "_seen"}, {31'b0, ok}, 32'd1);
    chk({tag, "_data"}, {24'b0, eng_tx_data}, {24'b0, m_tx});
    m_tx_full = 0;
  endtask

  task automatic done(input logic [7:0] r, input int dly);
    tick(dly);
    eng_rx_data = r; eng_done = 1'b1;
    @(posedge clk); #1;
    eng_done = 1'b0;
    if (m_rx_full) m_rx_ovf = 1;
    else begin m_rx = r; m_rx_full = 1; end
  endtask

  task automatic xfer_end();
    tick(3);
    m_busy = 0;
    m_done = 1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  old_rx, nb, y;
    int          k;

    rst = 1'b0; addr = '0; wd = '0; ctrl = 2'd0; eng_done = 1'b0; eng_rx_data = '0;
    {m_busy, m_tx_full, m_rx_full, m_done, m_rx_ovf, m_tx_ovf} = '0;
    m_tx = '0; m_rx = '0;
    tick(2);
    chk("rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
    chk("rst_start", {31'b0, eng_start}, 32'd0);
    chk("rst_txdata", {24'b0, eng_tx_data}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b1;
    tick(1);
    st_chk("rst_status");

    // Single byte, exact cs/start/hold timing.
    txwr(8'hA5);
    go(8'd0, 1'b0);
    chk("a_cs_at_go", {31'b0, spi_cs_n}, 32'd1);
    tick(1);
    chk("a_cs_low", {31'b0, spi_cs_n}, 32'd0);
    tick(2);
    chk("a_no_early_start", {31'b0, eng_start}, 32'd0);
    tick(1);
    chk("a_start_lat", {31'b0, eng_start}, 32'd1);
    start_chk("a_start");
    st_chk("a_busy_st");
    done(8'h3C, 0);
    chk("a_cs_hold0", {31'b0, spi_cs_n}, 32'd0);
    tick(1);
    chk("a_cs_hold1", {31'b0, spi_cs_n}, 32'd0);
    tick(1);
    chk("a_cs_high", {31'b0, spi_cs_n}, 32'd1);
    m_busy = 0; m_done = 1;
    rdrx_chk("a_rx");
    cpu_rd(SPI_STATUS, d);
    chk("a_status_08", d, 32'h08);
    w1c(32'h08);
    st_chk("a_status_clr");

    // Three-byte burst with TX refilled only during LOAD stalls.
    k = n_start;
    txwr(8'($urandom));
    go(8'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      start_chk("b_start");
      done(8'($urandom), int'($urandom_range(0, 3)));
      if (i < 2) begin
        tick(3);
        chk("b_stall_cs", {31'b0, spi_cs_n}, 32'd0);
        st_chk("b_stall_st");
        rdrx_chk("b_rx");
        txwr(8'($urandom));
      end
    end
    xfer_end();
    rdrx_chk("b_rx_last");
    st_chk("b_done_st");
    chk("b_nstart", n_start - k, 32'd3);
    w1c(32'h08);

    // TX overflow while idle; first byte retained.
    txwr(8'h11);
    txwr(8'h22);
    st_chk("c_ovf_st");
    w1c(32'h20);
    st_chk("c_ovf_clr");
    go(8'd0, 1'b0);
    start_chk("c_start");
    done(8'($urandom), 1);
    xfer_end();
    rdrx_chk("c_rx");
    st_chk("c_done_st");
    w1c(32'h08);

    // Two-byte burst, RX never read: first byte kept, rx_ovf set.
    txwr(8'($urandom));
    go(8'd1, 1'b0);
    start_chk("d_start0");
    done(8'($urandom), int'($urandom_range(0, 3)));
    txwr(8'($urandom));
    start_chk("d_start1");
    done(8'($urandom), int'($urandom_range(0, 3)));
    xfer_end();
    st_chk("d_ovf_st");
    rdrx_chk("d_rx_first");
    st_chk("d_after_rd");
    w1c(32'h38);
    st_chk("d_clr");

    // Abort mid-SHIFT on a six-byte burst, irq enabled.
    txwr(8'($urandom));
    go(8'd5, 1'b1);
    start_chk("e_start");
    cpu_wr(SPI_CTRL, 32'h0506);
    chk("e_irq_pre", {31'b0, irq}, 32'd0);
    y = 8'($urandom);
    txwr(y);
    k = n_start;
    done(8'($urandom), int'($urandom_range(0, 3)));
    chk("e_cs_hold0", {31'b0, spi_cs_n}, 32'd0);
    tick(1);
    chk("e_cs_hold1", {31'b0, spi_cs_n}, 32'd0);
    tick(1);
    chk("e_cs_high", {31'b0, spi_cs_n}, 32'd1);
    chk("e_irq", {31'b0, irq}, 32'd1);
    m_busy = 0; m_done = 1;
    tick(5);
    chk("e_no_more_start", n_start - k, 32'd0);
    st_chk("e_st");
    w1c(32'h08);
    chk("e_irq_clr", {31'b0, irq}, 32'd0);

    // RXDATA read in the same cycle as a capture with rx_full set.
    old_rx = m_rx;
    go(8'd0, 1'b0);
    start_chk("f_start");
    tick(1);
    nb = 8'($urandom);
    addr = SPI_RXDATA; ctrl = `MF; eng_rx_data = nb; eng_done = 1'b1;
    #1 d = data_out;
    @(posedge clk); #1;
    ctrl = 2'd0; eng_done = 1'b0;
    chk("f_rd_old", d, {24'b0, old_rx});
    m_rx = nb; m_rx_full = 1;
    xfer_end();
    st_chk("f_st");
    rdrx_chk("f_rx_new");
    w1c(32'h08);

    // Spurious eng_done while idle.
    eng_rx_data = 8'($urandom); eng_done = 1'b1;
    tick(1);
    eng_done = 1'b0;
    st_chk("g_spurious_st");
    chk("g_cs", {31'b0, spi_cs_n}, 32'd1);

    // Reset asserted during SHIFT.
    txwr(8'($urandom));
    go(8'd3, 1'b1);
    start_chk("h_start");
    #1 rst = 1'b0;
    #1;
    chk("h_cs_async", {31'b0, spi_cs_n}, 32'd1);
    chk("h_start_clr", {31'b0, eng_start}, 32'd0);
    chk("h_irq", {31'b0, irq}, 32'd0);
    addr = SPI_STATUS; ctrl = `MF;
    #1 chk("h_status", data_out, 32'd0);
    ctrl = 2'd0;
    tick(1);
    rst = 1'b1;
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer between the CPU coprocessor-0 move interface (MTC0/MFC0) and the SPI shift engines.
- Owns the chip-select, a one-entry TX holding register, a one-entry RX holding register and a burst counter.
- Starts one full-duplex byte at a time on the mosi/miso engines through a start/done handshake.
- Software therefore never touches engine timing directly.

Parameters:
W_DATA, 8, SPI byte width
W_LEN, 8, burst length field width (bytes per transfer = LEN+1)
CS_SETUP, 2, clk cycles with cs_n low before the first byte starts
CS_HOLD, 2, clk cycles after the last eng_done before cs_n returns high

Ports:
clk  in  1  system clock; all state changes on posedge
rst  in  1  asynchronous, active-low reset
addr  in  `W_REG  register select (0 CTRL, 1 STATUS, 2 TXDATA, 3 RXDATA; others read 0, writes ignored)
wd  in  `W_CPU  CPU write data
ctrl  in  `W_SPI_CTRL  `MT = write this cycle, `MF = read this cycle, other = no access
data_out  out  `W_CPU  read data, combinational on addr when ctrl==`MF, else 0
eng_start  out  1  one-cycle pulse: engine shifts eng_tx_data
eng_tx_data  out  W_DATA  byte for the engine, stable from eng_start until eng_done
eng_done  in  1  one-cycle pulse: byte finished; eng_rx_data valid this cycle
eng_rx_data  in  W_DATA  byte received on MISO
spi_cs_n  out  1  chip select, active low
irq  out  1  done_sticky & irq_en

Behaviour:
- Reset values: spi_cs_n=1, eng_start=0, eng_tx_data=0, irq=0, all flags 0, state IDLE, TX/RX holding registers empty.
- Access rule: each cycle with ctrl==`MT or `MF is exactly one access, committed at that posedge.
- CTRL write fields: wd[0] go, wd[1] abort, wd[2] irq_en (stored), wd[15:8] LEN (stored).
  - go is honoured only in IDLE; otherwise it is ignored.
- STATUS read: bit0 busy (state!=IDLE), bit1 tx_full, bit2 rx_full, bit3 done_sticky, bit4 rx_ovf, bit5 tx_ovf.
- STATUS write: bits 3–5 are write-1-to-clear.
- TXDATA write: loads the TX holding register and sets tx_full.
  - If tx_full is already 1, the write is dropped and tx_ovf is set.
- RXDATA read: returns {0, rx_byte}. The same posedge clears rx_full.
- FSM transitions:
  - IDLE: on go, latch cnt=LEN and go to SETUP at the next edge; spi_cs_n=0 from that edge.
  - SETUP: count CS_SETUP cycles, then go to LOAD.
  - LOAD: if tx_full, copy TX to eng_tx_data, clear tx_full, pulse eng_start and go to SHIFT. If TX is empty, stall with CS held low.
  - SHIFT: wait for eng_done, then capture the received byte.
    - If rx_full is 0: store the byte and set rx_full.
    - If rx_full is 1: drop the new byte, keep the old one, set rx_ovf.
    - Then if cnt==0 go to HOLD; else decrement cnt and go to LOAD.
  - HOLD: count CS_HOLD cycles, set spi_cs_n=1 and done_sticky, go to IDLE.
- Latency: a go write at edge N gives cs_n low at N+1. The first eng_start is at N+1+CS_SETUP+1 if TX is already full.
- Abort:
  - In SETUP or LOAD: go to HOLD at the next edge.
  - In SHIFT: the current byte completes (its rx byte is captured), then go to HOLD regardless of cnt.
  - Sets done_sticky like a normal end.
- Same-cycle write and pop: a TXDATA write in the same cycle LOAD empties TX is accepted, because the pop takes priority.
- Same-cycle read and capture: an RXDATA read in the same cycle as eng_done with rx_full=1 returns the old byte. The new byte is then stored with no overflow.
- Spurious eng_done outside SHIFT is ignored.
- Reset asserted mid-transfer: immediate return to reset values. cs_n goes high asynchronously.

Decomposition:
- Shared opcodes/package additions:
  - address constants SPI_CTRL/SPI_STATUS/SPI_TXDATA/SPI_RXDATA
  - STATUS bit indices
  - state encoding IDLE/SETUP/LOAD/SHIFT/HOLD
- `MT/`MF and `W_SPI_CTRL are reused unchanged.
- Single module; the cycle counter for SETUP/HOLD is shared and inline, with no sub-module.

Test Plan:
- Reset while in SHIFT with cs_n=0 -> cs_n=1, STATUS=0, eng_start=0 before the next edge.
- TXDATA=0xA5, CTRL=0x0001 (LEN=0) -> cs_n low 1 cycle later; one eng_start with eng_tx_data=0xA5 after 2 SETUP cycles. Then eng_done with rx=0x3C -> RXDATA reads 0x3C; cs_n high 2 cycles later; STATUS=0x08.
- LEN=2, TX refilled only after each STATUS poll shows tx_full=0 -> 3 eng_start pulses; cs_n stays low throughout the LOAD stalls; done_sticky set once.
- Two TXDATA writes (0x11, 0x22) without a transfer -> TX holds 0x11; STATUS bit5=1; W1C 0x20 clears it.
- LEN=1, RX never read -> first byte retained, rx_ovf=1 after the second eng_done.
- Abort written mid-SHIFT with LEN=5 -> the current byte completes, no further eng_start, cs_n high after CS_HOLD, irq=1 when irq_en=1.
